ugt_serial_arbiter: RTL and testbench
=====================================

// Module: ugt_serial_arbiter
// PURPOSE
// Shares one SLICE-bit subtract-with-carry slice (Invert + FullAdder carry
// chain, as used by the UGT/Sub comparators) among NREQ requesters.
// Each accepted request is a WIDTH-bit unsigned compare A > B. It is computed
// serially, LSB slice first, over WIDTH/SLICE cycles.
// Sits between request-issuing control blocks and the single shared compare slice.
// PARAMETERS
// WIDTH  8  operand width in bits; WIDTH % SLICE == 0 required
// SLICE  2  bits processed per cycle (width of the shared subtract slice)
// NREQ   2  number of requesters, 2..8
// PORTS
// CLK          in   1           rising-edge clock
// ASYNCRESETN  in   1           reset, asynchronous assert, active low
// REQ_VALID    in   NREQ        request valid, one bit per requester
// REQ_READY    out  NREQ        one-hot grant; a request is accepted on VALID&READY
// REQ_A        in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
// REQ_B        in   NREQ*WIDTH  operand B, same packing as REQ_A
// RSP_VALID    out  1           response valid
// RSP_READY    in   1           response consumed on RSP_VALID&RSP_READY
// RSP_ID       out  clog2(NREQ) index of the requester that owns the response
// RSP_GT       out  1           1 iff A > B (unsigned)
// RSP_EQ       out  1           1 iff A == B
// BUSY         out  1           high in RUN or RESP
// BEHAVIOUR
// - Reset values: state=IDLE; REQ_READY=0; RSP_VALID=0; RSP_ID=0; RSP_GT=0;
//   RSP_EQ=0; BUSY=0; last_grant=NREQ-1, so requester 0 wins first.
// - FSM states are IDLE, RUN and RESP.
// - IDLE:
//   - The grant is round-robin: search starts at last_grant+1 and wraps.
//   - REQ_READY is combinational and one-hot to the first valid requester.
//   - REQ_READY is 0 in every state other than IDLE.
//   - On the handshake: latch A and B; ID<-g; last_grant<-g; idx<-0;
//     carry<-1; zero<-1; go to RUN.
// - RUN, one slice per cycle at idx:
//   - The slice computes B[idx] + ~A[idx] + carry, i.e. B - A.
//   - carry <- COUT.
//   - zero <- zero & (slice sum == 0).
//   - idx <- idx+1.
// - Leaving RUN:
//   - On the last slice (idx == WIDTH/SLICE-1), go to RESP.
//   - Register RSP_GT = ~final COUT.
//   - Register RSP_EQ = final zero.
// - Latency: the handshake happens on edge E0; RSP_VALID is high after edge
//   E(WIDTH/SLICE). That is 4 cycles at the defaults.
// - RESP:
//   - RSP_VALID=1, with ID/GT/EQ held stable until RSP_READY.
//   - On RSP_VALID&RSP_READY: RSP_VALID<-0 and go to IDLE.
//   - There is no accept in the same cycle as the response is consumed.
//   - Minimum spacing between accepts is WIDTH/SLICE+2 cycles.
// - Requests are non-preemptive. REQ_* changes after the accept have no
//   effect on the result in flight.
// - A requester that is not granted must hold VALID and its operands. It is
//   served within NREQ grants.
// - Boundary cases:
//   - A=0, B=0 gives GT=0, EQ=1.
//   - A=2^WIDTH-1, B=0 gives GT=1, EQ=0; the borrow propagates through all slices.
//   - A=0, B=2^WIDTH-1 gives GT=0, EQ=0.
// - Reset mid-operation: all state returns to reset values immediately. The
//   in-flight result is discarded and no response is emitted for it.
// - RSP_ID, RSP_GT and RSP_EQ are don't-care while RSP_VALID=0. The bench
//   checks them only under RSP_VALID.
// TESTING
// 1) Hold ASYNCRESETN low, then release -> all outputs 0 and REQ_READY=0
//    with no valid requests.
// 2) Req0 A=200 B=100, RSP_READY=1 -> READY[0] pulses once; 4 cycles later
//    RSP_VALID=1, ID=0, GT=1, EQ=0.
// 3) Req1 A=0x55 B=0x55 -> GT=0, EQ=1, ID=1. Then A=0 B=0xFF -> GT=0, EQ=0.
// 4) Req0 A=0xFF B=0x00 -> GT=1, which exercises borrow through all 4 slices.
// 5) Both requesters valid continuously, RSP_READY=1 -> grant order 0,1,0,1;
//    accepts exactly 6 cycles apart.
// 6) RSP_READY held 0 for 5 cycles -> RSP_* stable, BUSY=1, REQ_READY=0;
//    the first cycle with READY=1 clears the response.
// 7) Reset asserted at idx=2 of RUN -> no RSP_VALID ever appears for that request.
//    After release, the request still valid is re-accepted and produces a
//    correct fresh result.

Source files
------------

// File: rtl/ugt_serial_arbiter.sv
// ugt_serial_arbiter
//
// Purpose:
//   Shares one SLICE-bit subtract-with-carry slice (inverted A plus a full-adder
//   carry chain) among NREQ requesters. Each accepted request is an unsigned
//   WIDTH-bit compare A > B. It is evaluated serially, LSB slice first, over
//   WIDTH/SLICE cycles. Requesters are granted round-robin and are never
//   preempted.
//
// Ports:
//   CLK          in   rising-edge clock
//   ASYNCRESETN  in   asynchronous active-low reset
//   REQ_VALID    in   [NREQ]        request valid per requester
//   REQ_READY    out  [NREQ]        one-hot grant, only while idle
//   REQ_A        in   [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   REQ_B        in   [NREQ*WIDTH]  operand B, same packing
//   RSP_VALID    out  response valid
//   RSP_READY    in   response consumed on RSP_VALID & RSP_READY
//   RSP_ID       out  [clog2(NREQ)] requester owning the response
//   RSP_GT       out  1 iff A > B
//   RSP_EQ       out  1 iff A == B
//   BUSY         out  high while a compare is running or awaiting pickup

module ugt_serial_arbiter #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2,
    parameter int NREQ  = 2
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESETN,
    input  logic [NREQ-1:0]          REQ_VALID,
    output logic [NREQ-1:0]          REQ_READY,
    input  logic [NREQ*WIDTH-1:0]    REQ_A,
    input  logic [NREQ*WIDTH-1:0]    REQ_B,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic [$clog2(NREQ)-1:0]  RSP_ID,
    output logic                     RSP_GT,
    output logic                     RSP_EQ,
    output logic                     BUSY
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDW    = $clog2(NREQ);
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic             handshake;
    logic [WIDTH-1:0] req_a_sel;
    logic [WIDTH-1:0] req_b_sel;
    logic [SLICE:0]   slice_res;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;

    // Round-robin search: start one past the last winner and wrap, so every
    // waiting requester is reached within NREQ grants.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant_q) + k) % NREQ;
            if (!grant_found && REQ_VALID[IDW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
    end

    // The grant is only offered while idle; this is what makes requests
    // non-preemptive and forbids an accept in the response-consume cycle.
    always_comb begin
        REQ_READY = '0;
        if (state_q == IDLE && grant_found) begin
            REQ_READY[grant_idx] = 1'b1;
        end
    end

    assign handshake = |(REQ_VALID & REQ_READY);

    // Operand mux for the winning requester.
    always_comb begin
        req_a_sel = WIDTH'(REQ_A >> (int'(grant_idx) * WIDTH));
        req_b_sel = WIDTH'(REQ_B >> (int'(grant_idx) * WIDTH));
    end

    // The shared slice computes B + ~A + carry on the low SLICE bits of the
    // latched operands. The operands shift right each cycle, so the low bits
    // always hold slice idx. A final carry of 0 means a borrow, i.e. A > B.
    assign slice_res  = {1'b0, b_q[SLICE-1:0]} + {1'b0, ~a_q[SLICE-1:0]}
                      + {{SLICE{1'b0}}, carry_q};
    assign slice_sum  = slice_res[SLICE-1:0];
    assign slice_cout = slice_res[SLICE];

    // Next-state and datapath control for the IDLE / RUN / RESP sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        zero_d       = zero_q;
        gt_d         = gt_q;
        eq_d         = eq_q;

        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    a_d          = req_a_sel;
                    b_d          = req_b_sel;
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    idx_d        = '0;
                    carry_d      = 1'b1;
                    zero_d       = 1'b1;
                    state_d      = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                carry_d = slice_cout;
                zero_d  = zero_q & (slice_sum == '0);
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDXW'(NSLICE - 1)) begin
                    gt_d    = ~slice_cout;
                    eq_d    = zero_q & (slice_sum == '0);
                    state_d = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset discards any compare in flight.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            gt_q         <= 1'b0;
            eq_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            zero_q       <= zero_d;
            gt_q         <= gt_d;
            eq_q         <= eq_d;
        end
    end

    assign RSP_VALID = (state_q == RESP);
    assign RSP_ID    = id_q;
    assign RSP_GT    = gt_q;
    assign RSP_EQ    = eq_q;
    assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_ugt_serial_arbiter.sv
// tb_ugt_serial_arbiter
//
// Purpose:
//   Directed testbench for ugt_serial_arbiter at default parameters
//   (WIDTH=8, SLICE=2, NREQ=2). Expected values are hand-computed constants.

module tb_ugt_serial_arbiter;

    logic        CLK;
    logic        ASYNCRESETN;
    logic [1:0]  REQ_VALID;
    logic [1:0]  REQ_READY;
    logic [15:0] REQ_A;
    logic [15:0] REQ_B;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [0:0]  RSP_ID;
    logic        RSP_GT;
    logic        RSP_EQ;
    logic        BUSY;

    int vectors;
    int miscompares;
    int cycle;
    int acceptCyc[$];
    int acceptId[$];

    ugt_serial_arbiter #(
        .WIDTH(8),
        .SLICE(2),
        .NREQ (2)
    ) dut (
        .CLK        (CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_A      (REQ_A),
        .REQ_B      (REQ_B),
        .RSP_VALID  (RSP_VALID),
        .RSP_READY  (RSP_READY),
        .RSP_ID     (RSP_ID),
        .RSP_GT     (RSP_GT),
        .RSP_EQ     (RSP_EQ),
        .BUSY       (BUSY)
    );

    // 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Records the cycle number and winner of every handshake so accept
    // spacing and grant order can be checked afterwards.
    always @(posedge CLK) begin
        cycle = cycle + 1;
        if (ASYNCRESETN && (|(REQ_READY & REQ_VALID))) begin
            acceptCyc.push_back(cycle);
            acceptId.push_back(REQ_READY[1] ? 1 : 0);
        end
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid,
                                 input logic [7:0] a0, input logic [7:0] b0,
                                 input logic [7:0] a1, input logic [7:0] b1);
        REQ_VALID = valid;
        REQ_A     = {a1, a0};
        REQ_B     = {b1, b0};
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors = vectors + 1;
        assert (observed === expected) else begin
            miscompares = miscompares + 1;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One transaction from an idle sample point: check the grant, accept,
    // optionally drop and scramble the request, then check the response
    // appears exactly four edges after the accept. Returns in RESP.
    task automatic runTxn(input int id, input bit expGt, input bit expEq,
                          input bit dropValid, input string tag);
        #1;
        checkOutput({tag, ".grant"}, {30'd0, REQ_READY}, 32'd1 << id);
        tick();
        checkOutput({tag, ".busy"}, {31'd0, BUSY}, 32'd1);
        checkOutput({tag, ".readyLow"}, {30'd0, REQ_READY}, 32'd0);
        if (dropValid) begin
            REQ_VALID = 2'b00;
            REQ_A     = ~REQ_A;
            REQ_B     = ~REQ_B;
        end
        tick();
        tick();
        tick();
        checkOutput({tag, ".earlyRsp"}, {31'd0, RSP_VALID}, 32'd0);
        tick();
        checkOutput({tag, ".rspValid"}, {31'd0, RSP_VALID}, 32'd1);
        checkOutput({tag, ".rspId"}, {31'd0, RSP_ID}, id);
        checkOutput({tag, ".rspGt"}, {31'd0, RSP_GT}, {31'd0, expGt});
        checkOutput({tag, ".rspEq"}, {31'd0, RSP_EQ}, {31'd0, expEq});
    endtask

    // Directed sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        cycle       = 0;
        ASYNCRESETN = 1'b0;
        RSP_READY   = 1'b0;
        applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0);

        // Reset held, then released.
        tick();
        tick();
        checkOutput("rst.busy", {31'd0, BUSY}, 32'd0);
        checkOutput("rst.rspValid", {31'd0, RSP_VALID}, 32'd0);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        tick();
        checkOutput("rel.ready", {30'd0, REQ_READY}, 32'd0);
        checkOutput("rel.rspValid", {31'd0, RSP_VALID}, 32'd0);
        checkOutput("rel.rspId", {31'd0, RSP_ID}, 32'd0);
        checkOutput("rel.rspGt", {31'd0, RSP_GT}, 32'd0);
        checkOutput("rel.rspEq", {31'd0, RSP_EQ}, 32'd0);
        checkOutput("rel.busy", {31'd0, BUSY}, 32'd0);

        // Req0 200 vs 100.
        RSP_READY = 1'b1;
        applyStimulus(2'b01, 8'd200, 8'd100, 8'd0, 8'd0);
        runTxn(0, 1'b1, 1'b0, 1'b1, "t2");
        tick();
        checkOutput("t2.done", {31'd0, RSP_VALID}, 32'd0);
        checkOutput("t2.idle", {31'd0, BUSY}, 32'd0);

        // Req1 equal operands, then A=0 B=0xFF.
        applyStimulus(2'b10, 8'd0, 8'd0, 8'h55, 8'h55);
        runTxn(1, 1'b0, 1'b1, 1'b1, "t3a");
        tick();
        applyStimulus(2'b10, 8'd0, 8'd0, 8'h00, 8'hFF);
        runTxn(1, 1'b0, 1'b0, 1'b1, "t3b");
        tick();

        // Both requesters valid: alternate 0,1,0,1 with six-cycle spacing.
        acceptCyc.delete();
        acceptId.delete();
        applyStimulus(2'b11, 8'd10, 8'd20, 8'd30, 8'd7);
        runTxn(0, 1'b0, 1'b0, 1'b0, "t5g0");
        tick();
        runTxn(1, 1'b1, 1'b0, 1'b0, "t5g1");
        tick();
        runTxn(0, 1'b0, 1'b0, 1'b0, "t5g2");
        tick();
        runTxn(1, 1'b1, 1'b0, 1'b0, "t5g3");
        REQ_VALID = 2'b00;
        tick();
        checkOutput("t5.count", acceptCyc.size(), 32'd4);
        if (acceptCyc.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                checkOutput($sformatf("t5.spacing%0d", i),
                            acceptCyc[i] - acceptCyc[i-1], 32'd6);
                checkOutput($sformatf("t5.order%0d", i), acceptId[i], i % 2);
            end
            checkOutput("t5.order0", acceptId[0], 32'd0);
        end

        // Req0 0xFF vs 0x00: borrow through every slice.
        applyStimulus(2'b01, 8'hFF, 8'h00, 8'd0, 8'd0);
        runTxn(0, 1'b1, 1'b0, 1'b1, "t4");
        tick();

        // Response back-pressure with another requester waiting.
        RSP_READY = 1'b0;
        applyStimulus(2'b10, 8'd0, 8'd0, 8'h00, 8'h00);
        runTxn(1, 1'b0, 1'b1, 1'b1, "t6");
        applyStimulus(2'b01, 8'h81, 8'h80, 8'd0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("t6.hold%0d.valid", i), {31'd0, RSP_VALID}, 32'd1);
            checkOutput($sformatf("t6.hold%0d.id", i), {31'd0, RSP_ID}, 32'd1);
            checkOutput($sformatf("t6.hold%0d.gt", i), {31'd0, RSP_GT}, 32'd0);
            checkOutput($sformatf("t6.hold%0d.eq", i), {31'd0, RSP_EQ}, 32'd1);
            checkOutput($sformatf("t6.hold%0d.busy", i), {31'd0, BUSY}, 32'd1);
            checkOutput($sformatf("t6.hold%0d.ready", i), {30'd0, REQ_READY}, 32'd0);
        end
        RSP_READY = 1'b1;
        tick();
        checkOutput("t6.consumed", {31'd0, RSP_VALID}, 32'd0);
        checkOutput("t6.idle", {31'd0, BUSY}, 32'd0);
        checkOutput("t6.nextGrant", {30'd0, REQ_READY}, 32'd1);

        // Req0 accepted, reset lands while idx=2; no response may appear.
        tick();
        checkOutput("t7.busy", {31'd0, BUSY}, 32'd1);
        tick();
        tick();
        ASYNCRESETN = 1'b0;
        #1;
        checkOutput("t7.rstBusy", {31'd0, BUSY}, 32'd0);
        checkOutput("t7.rstRsp", {31'd0, RSP_VALID}, 32'd0);
        tick();
        checkOutput("t7.rstRsp1", {31'd0, RSP_VALID}, 32'd0);
        tick();
        checkOutput("t7.rstRsp2", {31'd0, RSP_VALID}, 32'd0);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        runTxn(0, 1'b1, 1'b0, 1'b1, "t7");
        tick();
        checkOutput("t7.done", {31'd0, RSP_VALID}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
